// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefStride    = 4;
  localparam int unsigned DefFifoDepth = 4;

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] pc;
    logic [DefDataWidth-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch buffer: head entry is visible the cycle after it is pushed.
// Flush has priority over push and pop; pop on empty is ignored.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CntFull) || w_pop);

  always_ff @(posedge clk) begin
    if (!resetn || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding memory
// requests, prefetch FIFO and redirect/flush. FETCH_PERF_CNT_EN adds stall_cycles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned           DATA_WIDTH   = DefDataWidth,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned           STRIDE       = DefStride,
  parameter int unsigned           FIFO_DEPTH   = DefFifoDepth
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  mem_req,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int unsigned           CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0]       CntFull = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] Stride  = ADDR_WIDTH'(STRIDE);

  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_pend_pc;
  logic                  r_mem_req;
  logic                  w_xfer;
  logic                  w_push;
  logic                  w_pop;
  logic [CntW-1:0]       w_count;
  logic [CntW-1:0]       w_count_nxt;
  entry_t                w_wr_entry;
  entry_t                w_head;

  assign w_xfer = r_mem_req && mem_ready;
  assign w_push = w_xfer && (r_state == RUN) && !redirect_valid;
  assign w_pop  = instr_valid && instr_ready && !redirect_valid;

  assign w_wr_entry.pc   = r_addr;
  assign w_wr_entry.data = data_in;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_wdata (w_wr_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_valid (instr_valid),
    .o_count (w_count)
  );

  // Occupancy after this cycle; issue decisions count the request about to be made.
  always_comb begin
    w_count_nxt = w_count;
    if (redirect_valid)        w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = w_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = w_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= RUN;
      r_addr    <= RESET_VECTOR;
      r_pend_pc <= RESET_VECTOR;
      r_mem_req <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (r_mem_req && !mem_ready) begin
            // Request must stay stable; a redirect waits for its response in DROP.
            if (redirect_valid) begin
              r_state   <= DROP;
              r_pend_pc <= redirect_pc;
            end
          end else begin
            if (redirect_valid) r_addr <= redirect_pc;
            else if (w_xfer)    r_addr <= r_addr + Stride;
            r_mem_req <= (w_count_nxt < CntFull);
          end
        end
        DROP: begin
          if (mem_ready) begin
            r_state   <= RUN;
            r_addr    <= redirect_valid ? redirect_pc : r_pend_pc;
            r_mem_req <= (w_count_nxt < CntFull);
          end else if (redirect_valid) begin
            r_pend_pc <= redirect_pc;
          end
        end
      endcase
    end
  end

  assign address    = r_addr;
  assign mem_req    = r_mem_req;
  assign we         = 1'b0;
  assign data_out   = '0;
  assign instr_data = w_head.data;
  assign instr_pc   = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stall_cycles <= '0;
    end else if (!instr_valid && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of fetched words plus directed checks,
// and a second instance with a reset vector near the top of the address space.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] WrapVector = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_ready;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic        we;
  logic        instr_valid;

  logic        wrap_one = 1'b1;
  logic        wrap_zero = 1'b0;
  logic [31:0] wrap_zero_pc = 32'h0;
  logic [31:0] wrap_address;
  logic [31:0] wrap_data_in;
  logic [31:0] wrap_data_out;
  logic [31:0] wrap_instr_data;
  logic [31:0] wrap_instr_pc;
  logic        wrap_mem_req;
  logic        wrap_we;
  logic        wrap_instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] wrap_stall_cycles;
`endif

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_xfer = 0;
  int           n_pop = 0;
  fetch_entry_t sb[$];
  fetch_entry_t e_exp;
  logic [31:0]  model_pc = 32'h0;
  bit           model_drop = 1'b0;
  logic [31:0]  wrap_pc_q[$];
  logic [31:0]  wrap_data_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign data_in      = mem_word(address);
  assign wrap_data_in = mem_word(wrap_address);

  fetch_unit u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .address        (address),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .data_in        (data_in),
    .we             (we),
    .data_out       (data_out),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  fetch_unit #(
    .RESET_VECTOR (WrapVector)
  ) u_dut_wrap (
    .clk            (clk),
    .resetn         (resetn),
    .address        (wrap_address),
    .mem_req        (wrap_mem_req),
    .mem_ready      (wrap_one),
    .data_in        (wrap_data_in),
    .we             (wrap_we),
    .data_out       (wrap_data_out),
    .instr_valid    (wrap_instr_valid),
    .instr_data     (wrap_instr_data),
    .instr_pc       (wrap_instr_pc),
    .instr_ready    (wrap_one),
    .redirect_valid (wrap_zero),
    .redirect_pc    (wrap_zero_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (wrap_stall_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  // Scoreboard monitor: models what the DUT will do at the coming posedge.
  always @(negedge clk) begin
    if (!resetn) begin
      sb.delete();
      model_pc   = 32'h0;
      model_drop = 1'b0;
    end else begin
      check_eq("instr_valid", 64'(instr_valid), 64'(sb.size() != 0));
      check_eq("we_zero", 64'(we), 64'h0);
      if (redirect_valid) begin
        model_drop = mem_req && !mem_ready;
        sb.delete();
        model_pc = redirect_pc;
      end else begin
        if (instr_valid && instr_ready && (sb.size() != 0)) begin
          e_exp = sb.pop_front();
          check_eq("instr_pc", 64'(instr_pc), 64'(e_exp.pc));
          check_eq("instr_data", 64'(instr_data), 64'(e_exp.data));
          n_pop++;
        end
        if (mem_req && mem_ready) begin
          n_xfer++;
          if (model_drop) begin
            model_drop = 1'b0;
          end else begin
            check_eq("fetch_addr", 64'(address), 64'(model_pc));
            e_exp.pc   = model_pc;
            e_exp.data = mem_word(model_pc);
            sb.push_back(e_exp);
            model_pc = model_pc + 32'd4;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && wrap_instr_valid && (wrap_pc_q.size() < 3)) begin
      wrap_pc_q.push_back(wrap_instr_pc);
      wrap_data_q.push_back(wrap_instr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int xb;
    int xt;
    logic [31:0] exp_pc;

    resetn = 1'b0;
    mem_ready = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step(3);
    resetn = 1'b1;

    // Reset state, then streaming fetch at one word per cycle.
    @(negedge clk);
    check_eq("rst_address", 64'(address), 64'h0);
    check_eq("rst_mem_req", 64'(mem_req), 64'h0);
    check_eq("rst_instr_valid", 64'(instr_valid), 64'h0);
    check_eq("rst_data_out", 64'(data_out), 64'h0);
    step(1);
    check_eq("first_req", 64'(mem_req), 64'h1);
    check_eq("first_addr", 64'(address), 64'h0);
    step(1);
    xb = n_pop;
    xt = n_xfer;
    step(8);
    check_eq("stream_pops", 64'(n_pop - xb), 64'd8);
    check_eq("stream_xfers", 64'(n_xfer - xt), 64'd8);

    // Consumer blocked: FIFO fills to depth, then one pop admits one more fetch.
    instr_ready = 1'b0;
    do_reset();
    xt = n_xfer;
    step(10);
    check_eq("full_xfers", 64'(n_xfer - xt), 64'd4);
    check_eq("full_no_req", 64'(mem_req), 64'h0);
    check_eq("full_valid", 64'(instr_valid), 64'h1);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    xt = n_xfer;
    step(5);
    check_eq("refill_xfers", 64'(n_xfer - xt), 64'd1);
    check_eq("refill_no_req", 64'(mem_req), 64'h0);
    instr_ready = 1'b1;

    // Memory stalls three cycles at 0x10.
    do_reset();
    step(5);
    check_eq("stall_start_addr", 64'(address), 64'h10);
    mem_ready = 1'b0;
    xt = n_xfer;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("stall_addr", 64'(address), 64'h10);
      check_eq("stall_req", 64'(mem_req), 64'h1);
    end
    check_eq("stall_xfers", 64'(n_xfer - xt), 64'd0);
    mem_ready = 1'b1;
    step(1);
    check_eq("stall_next_addr", 64'(address), 64'h14);
    step(3);

    // Redirect to 0x100 while the 0x20 request is pending.
    do_reset();
    step(9);
    check_eq("redir_pre_addr", 64'(address), 64'h20);
    mem_ready = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    check_eq("drop_hold_addr", 64'(address), 64'h20);
    check_eq("drop_hold_req", 64'(mem_req), 64'h1);
    step(1);
    check_eq("drop_flushed", 64'(instr_valid), 64'h0);
    mem_ready = 1'b1;
    step(1);
    check_eq("redir_addr", 64'(address), 64'h100);
    check_eq("redir_req", 64'(mem_req), 64'h1);
    check_eq("redir_dropped", 64'(instr_valid), 64'h0);
    step(1);
    check_eq("redir_next_addr", 64'(address), 64'h104);

    // Second redirect while in DROP replaces the pending PC; low bits pass through.
    mem_ready = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step(1);
    redirect_pc = 32'h206;
    step(1);
    redirect_valid = 1'b0;
    check_eq("drop2_hold_addr", 64'(address), 64'h104);
    check_eq("drop2_hold_req", 64'(mem_req), 64'h1);
    mem_ready = 1'b1;
    step(1);
    check_eq("drop2_addr", 64'(address), 64'h206);
    step(1);
    check_eq("drop2_next_addr", 64'(address), 64'h20A);
    step(3);

`ifdef FETCH_PERF_CNT_EN
    mem_ready = 1'b0;
    do_reset();
    step(10);
    check_eq("stall_cycles_ge10", 64'(stall_cycles >= 32'd10), 64'h1);
    mem_ready = 1'b1;
    step(2);
`endif

    check_eq("wrap_count", 64'(wrap_pc_q.size()), 64'd3);
    if (wrap_pc_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        exp_pc = WrapVector + 32'(4 * i);
        check_eq("wrap_pc", 64'(wrap_pc_q[i]), 64'(exp_pc));
        check_eq("wrap_data", 64'(wrap_data_q[i]), 64'(mem_word(exp_pc)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
